// File: rtl/regfile_pkg.sv
// Register-file constants and types shared by the writeback scheduler,
// the register bank and the issue stage.
package regfile_pkg;

  localparam int REG_COUNT = 16;
  localparam int IDX_W     = $clog2(REG_COUNT);
  localparam int DATA_W    = 32;

  typedef logic [IDX_W-1:0]  reg_idx_t;
  typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr;
// ptr moves just past the winner whenever the grant is consumed (advance).
module rr_arbiter #(
  parameter  int N     = 3,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_async_n,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] ptr
);

  localparam logic [N-1:0] ONE = N'(1);

  logic [N-1:0]     req_rot;
  logic [N-1:0]     gnt_rot;
  logic [PTR_W-1:0] ptr_nxt;

  // Rotate so the pointer lands at bit 0, isolate the lowest set bit, rotate back.
  assign req_rot = N'({req, req} >> ptr);
  assign gnt_rot = req_rot & (~req_rot + ONE);
  assign grant   = N'({gnt_rot, gnt_rot} >> (N - int'(ptr)));

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    ptr_nxt = ptr;
    for (int k = 0; k < N; k++) begin
      if (grant[k]) ptr_nxt = PTR_W'((k + 1) % N);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n)  ptr <= '0;
    else if (advance)  ptr <= ptr_nxt;
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler: round-robin access to the register bank's single write
// port through a registered stage, plus the busy-register scoreboard.
module regfile_wb_scheduler #(
  parameter int NUM_REQ   = 3,
  parameter int REG_COUNT = regfile_pkg::REG_COUNT,
  parameter int IDX_W     = regfile_pkg::IDX_W,
  parameter int DATA_W    = regfile_pkg::DATA_W
) (
  input  logic                      clk,
  input  logic                      rst_async_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*IDX_W-1:0]  req_index,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rf_write_en,
  output logic [IDX_W-1:0]          rf_write_index,
  output logic [DATA_W-1:0]         rf_write,
  input  logic                      rsv_valid,
  input  logic [IDX_W-1:0]          rsv_index,
  output logic                      rsv_ready,
  input  logic [IDX_W-1:0]          chk_a_index,
  input  logic [IDX_W-1:0]          chk_b_index,
  input  logic [IDX_W-1:0]          chk_c_index,
  output logic [2:0]                chk_busy,
  output logic [REG_COUNT-1:0]      busy,
  output logic                      err_unreserved
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]     rr_ptr;
  logic                 grant_any;
  logic [IDX_W-1:0]     grant_index;
  logic [DATA_W-1:0]    grant_data;
  logic [REG_COUNT-1:0] set_mask;
  logic [REG_COUNT-1:0] clr_mask;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk         (clk),
    .rst_async_n (rst_async_n),
    .req         (req_valid),
    .advance     (grant_any),
    .grant       (req_ready),
    .ptr         (rr_ptr)
  );

  assign grant_any = |req_ready;

  always_comb begin
    grant_index = '0;
    grant_data  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req_ready[k]) begin
        grant_index = req_index[k*IDX_W +: IDX_W];
        grant_data  = req_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // A busy register is refused even if its write is staged this cycle (WAW).
  assign rsv_ready = rsv_valid && (rsv_index == '0 || !busy[rsv_index]);
  assign set_mask  = REG_COUNT'(rsv_ready && rsv_index != '0) << rsv_index;
  assign clr_mask  = REG_COUNT'(rf_write_en) << rf_write_index;

  assign chk_busy[0] = (chk_a_index != '0) && busy[chk_a_index];
  assign chk_busy[1] = (chk_b_index != '0) && busy[chk_b_index];
  assign chk_busy[2] = (chk_c_index != '0) && busy[chk_c_index];

  // Busy clears on the same edge the bank captures the staged write.
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      busy           <= '0;
      rf_write_en    <= 1'b0;
      rf_write_index <= '0;
      rf_write       <= '0;
      err_unreserved <= 1'b0;
    end else begin
      busy           <= (busy & ~clr_mask) | set_mask;
      err_unreserved <= rf_write_en && !busy[rf_write_index];
      rf_write_en    <= grant_any && (grant_index != '0);
      if (grant_any) begin
        rf_write_index <= grant_index;
        rf_write       <= grant_data;
      end
    end
  end

  ptr_in_range: assert property (@(posedge clk) disable iff (!rst_async_n)
    {1'b0, rr_ptr} < (PTR_W + 1)'(NUM_REQ));

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed vector table, randomized traffic
// against a behavioural model, and a mid-traffic reset.
module tb_regfile_wb_scheduler;

  localparam int N  = 3;
  localparam int RC = 16;
  localparam int IW = 4;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst_async_n;
  logic [N-1:0]      req_valid;
  logic [N*IW-1:0]   req_index;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              rf_write_en;
  logic [IW-1:0]     rf_write_index;
  logic [DW-1:0]     rf_write;
  logic              rsv_valid;
  logic [IW-1:0]     rsv_index;
  logic              rsv_ready;
  logic [IW-1:0]     chk_a_index, chk_b_index, chk_c_index;
  logic [2:0]        chk_busy;
  logic [RC-1:0]     busy;
  logic              err_unreserved;

  always #5 clk = ~clk;

  regfile_wb_scheduler #(.NUM_REQ(N), .REG_COUNT(RC), .IDX_W(IW), .DATA_W(DW)) dut (
    .clk            (clk),
    .rst_async_n    (rst_async_n),
    .req_valid      (req_valid),
    .req_index      (req_index),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .rf_write_en    (rf_write_en),
    .rf_write_index (rf_write_index),
    .rf_write       (rf_write),
    .rsv_valid      (rsv_valid),
    .rsv_index      (rsv_index),
    .rsv_ready      (rsv_ready),
    .chk_a_index    (chk_a_index),
    .chk_b_index    (chk_b_index),
    .chk_c_index    (chk_c_index),
    .chk_busy       (chk_busy),
    .busy           (busy),
    .err_unreserved (err_unreserved)
  );

  // Register bank fed by the DUT's write port.
  logic [DW-1:0] bank [RC];
  always @(posedge clk) if (rf_write_en) bank[rf_write_index] <= rf_write;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic                  rsv_v;
    logic [IW-1:0]         rsv_i;
    logic [N-1:0]          rv;
    logic [N-1:0][IW-1:0]  ri;
    logic [N-1:0][DW-1:0]  rd;
    logic [IW-1:0]         ca, cb, cc;
    logic                  chk_en;
    logic [N-1:0]          e_rdy;
    logic                  e_rsv;
    logic [2:0]            e_chk;
    logic                  e_wen;
    logic                  e_err;
  } vec_t;

  function automatic vec_t mk(input logic rsv_v, input int rsv_i, input logic [N-1:0] rv,
                              input int i0, input int i1, input int i2, input logic [DW-1:0] d,
                              input int ca, input int cb, input int cc,
                              input logic [N-1:0] e_rdy, input logic e_rsv, input logic [2:0] e_chk,
                              input logic e_wen, input logic e_err);
    vec_t v;
    v.rsv_v = rsv_v;  v.rsv_i = IW'(rsv_i);  v.rv = rv;
    v.ri[0] = IW'(i0); v.ri[1] = IW'(i1); v.ri[2] = IW'(i2);
    for (int k = 0; k < N; k++) v.rd[k] = d;
    v.ca = IW'(ca); v.cb = IW'(cb); v.cc = IW'(cc);
    v.chk_en = 1'b1; v.e_rdy = e_rdy; v.e_rsv = e_rsv; v.e_chk = e_chk;
    v.e_wen = e_wen; v.e_err = e_err;
    return v;
  endfunction

  function automatic vec_t rnd();
    vec_t v;
    v.rsv_v = 1'($urandom_range(0, 1));
    v.rsv_i = IW'($urandom_range(0, 7));
    v.rv    = N'($urandom_range(0, 7));
    for (int k = 0; k < N; k++) begin
      v.ri[k] = IW'($urandom_range(0, 7));
      v.rd[k] = $urandom;
    end
    v.ca = IW'($urandom_range(0, 7)); v.cb = IW'($urandom_range(0, 7)); v.cc = IW'($urandom_range(0, 15));
    v.chk_en = 1'b0; v.e_rdy = '0; v.e_rsv = 1'b0; v.e_chk = '0; v.e_wen = 1'b0; v.e_err = 1'b0;
    return v;
  endfunction

  // Behavioural model: pointer as an integer, busy as a bit set, one staged write.
  int            m_ptr;
  logic [RC-1:0] m_busy;
  logic          m_wen;
  logic [IW-1:0] m_widx;
  logic [DW-1:0] m_wdata;
  logic          m_err;
  logic [DW-1:0] m_bank [RC];
  int            m_last_wr;

  task automatic m_reset();
    m_ptr = 0; m_busy = '0; m_wen = 1'b0; m_widx = '0; m_wdata = '0; m_err = 1'b0; m_last_wr = -1;
  endtask

  function automatic int m_winner();
    for (int i = 0; i < N; i++) begin
      int j = (m_ptr + i) % N;
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic m_rsv_ok();
    return rsv_valid && (rsv_index == 0 || !m_busy[rsv_index]);
  endfunction

  function automatic logic m_chk(input logic [IW-1:0] idx);
    return (idx != 0) && m_busy[idx];
  endfunction

  task automatic model_check();
    int k = m_winner();
    logic [N-1:0] e_rdy = (k >= 0) ? N'(1) << k : '0;
    check("req_ready", req_ready, e_rdy);
    check("rsv_ready", rsv_ready, m_rsv_ok());
    check("chk_busy", chk_busy, {m_chk(chk_c_index), m_chk(chk_b_index), m_chk(chk_a_index)});
    check("busy", busy, m_busy);
    check("rf_write_en", rf_write_en, m_wen);
    check("rf_write_index", rf_write_index, m_widx);
    check("rf_write", rf_write, m_wdata);
    check("err_unreserved", err_unreserved, m_err);
    if (m_last_wr >= 0) check("bank", bank[m_last_wr], m_bank[m_last_wr]);
  endtask

  task automatic model_step();
    int   k  = m_winner();
    logic ok = m_rsv_ok();
    m_last_wr = -1;
    m_err = m_wen && !m_busy[m_widx];
    if (m_wen) begin
      m_bank[m_widx] = m_wdata;
      m_busy[m_widx] = 1'b0;
      m_last_wr = int'(m_widx);
    end
    if (ok && rsv_index != 0) m_busy[rsv_index] = 1'b1;
    if (k >= 0) begin
      m_widx  = req_index[k*IW +: IW];
      m_wdata = req_data[k*DW +: DW];
      m_wen   = (m_widx != 0);
      m_ptr   = (k + 1) % N;
    end else begin
      m_wen = 1'b0;
    end
  endtask

  task automatic drive(input vec_t v);
    rsv_valid = v.rsv_v; rsv_index = v.rsv_i;
    req_valid = v.rv; req_index = v.ri; req_data = v.rd;
    chk_a_index = v.ca; chk_b_index = v.cb; chk_c_index = v.cc;
  endtask

  task automatic cycle(input vec_t v, input string tag);
    drive(v);
    @(negedge clk);
    model_check();
    if (v.chk_en) begin
      check({tag, ".rdy"}, req_ready, v.e_rdy);
      check({tag, ".rsv"}, rsv_ready, v.e_rsv);
      check({tag, ".chk"}, chk_busy, v.e_chk);
      check({tag, ".wen"}, rf_write_en, v.e_wen);
      check({tag, ".err"}, err_unreserved, v.e_err);
    end
    model_step();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];
  vec_t idle;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    idle = mk(0, 0, 3'b000, 0, 0, 0, '0, 0, 0, 0, '0, 0, '0, 0, 0);
    idle.chk_en = 1'b0;
    drive(idle);
    rst_async_n = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.busy", busy, '0);
    check("rst.wen", rf_write_en, 1'b0);
    check("rst.widx", rf_write_index, '0);
    check("rst.wdata", rf_write, '0);
    check("rst.err", err_unreserved, 1'b0);
    rst_async_n = 1'b1;
    @(posedge clk);
    #1;

    // rsv_v rsv_i rv i0 i1 i2 data ca cb cc | rdy rsv chk wen err
    tbl.push_back(mk(0, 0, 3'b111, 1, 2, 3, 32'h100, 0, 0, 0, 3'b001, 0, 3'b000, 0, 0));
    tbl.push_back(mk(0, 0, 3'b111, 1, 2, 3, 32'h101, 0, 0, 0, 3'b010, 0, 3'b000, 1, 0));
    tbl.push_back(mk(0, 0, 3'b111, 1, 2, 3, 32'h102, 0, 0, 0, 3'b100, 0, 3'b000, 1, 1));
    tbl.push_back(mk(0, 0, 3'b111, 1, 2, 3, 32'h103, 0, 0, 0, 3'b001, 0, 3'b000, 1, 1));
    tbl.push_back(mk(0, 0, 3'b111, 1, 2, 3, 32'h104, 0, 0, 0, 3'b010, 0, 3'b000, 1, 1));
    tbl.push_back(mk(0, 0, 3'b111, 1, 2, 3, 32'h105, 0, 0, 0, 3'b100, 0, 3'b000, 1, 1));
    tbl.push_back(mk(0, 0, 3'b000, 0, 0, 0, 32'h0,   0, 0, 0, 3'b000, 0, 3'b000, 1, 1));
    tbl.push_back(mk(0, 0, 3'b000, 0, 0, 0, 32'h0,   0, 0, 0, 3'b000, 0, 3'b000, 0, 1));
    tbl.push_back(mk(0, 0, 3'b000, 0, 0, 0, 32'h0,   0, 0, 0, 3'b000, 0, 3'b000, 0, 0));
    tbl.push_back(mk(1, 5, 3'b000, 0, 0, 0, 32'h0,   5, 0, 0, 3'b000, 1, 3'b000, 0, 0));
    tbl.push_back(mk(0, 0, 3'b010, 0, 5, 0, 32'hDEADBEEF, 5, 0, 5, 3'b010, 0, 3'b101, 0, 0));
    tbl.push_back(mk(1, 5, 3'b000, 0, 0, 0, 32'h0,   5, 0, 0, 3'b000, 0, 3'b001, 1, 0));
    tbl.push_back(mk(1, 5, 3'b000, 0, 0, 0, 32'h0,   5, 0, 0, 3'b000, 1, 3'b000, 0, 0));
    tbl.push_back(mk(1, 3, 3'b000, 0, 0, 0, 32'h0,   5, 3, 0, 3'b000, 1, 3'b001, 0, 0));
    tbl.push_back(mk(1, 3, 3'b000, 0, 0, 0, 32'h0,   5, 3, 0, 3'b000, 0, 3'b011, 0, 0));
    tbl.push_back(mk(0, 0, 3'b100, 0, 0, 3, 32'h33,  5, 3, 0, 3'b100, 0, 3'b011, 0, 0));
    tbl.push_back(mk(1, 3, 3'b000, 0, 0, 0, 32'h0,   5, 3, 0, 3'b000, 0, 3'b011, 1, 0));
    tbl.push_back(mk(1, 3, 3'b000, 0, 0, 0, 32'h0,   5, 3, 0, 3'b000, 1, 3'b001, 0, 0));
    tbl.push_back(mk(1, 0, 3'b000, 0, 0, 0, 32'h0,   0, 0, 0, 3'b000, 1, 3'b000, 0, 0));
    tbl.push_back(mk(0, 0, 3'b001, 0, 0, 0, 32'h55,  0, 0, 0, 3'b001, 0, 3'b000, 0, 0));
    tbl.push_back(mk(0, 0, 3'b000, 0, 0, 0, 32'h0,   0, 0, 0, 3'b000, 0, 3'b000, 0, 0));
    tbl.push_back(mk(0, 0, 3'b001, 7, 0, 0, 32'h12,  0, 0, 0, 3'b001, 0, 3'b000, 0, 0));
    tbl.push_back(mk(0, 0, 3'b000, 0, 0, 0, 32'h0,   0, 0, 0, 3'b000, 0, 3'b000, 1, 0));
    tbl.push_back(mk(0, 0, 3'b000, 0, 0, 0, 32'h0,   7, 0, 0, 3'b000, 0, 3'b000, 0, 1));
    tbl.push_back(mk(0, 0, 3'b000, 0, 0, 0, 32'h0,   0, 0, 0, 3'b000, 0, 3'b000, 0, 0));

    for (int i = 0; i < tbl.size(); i++) cycle(tbl[i], $sformatf("v%0d", i));

    check("bank.r5", bank[5], 32'hDEADBEEF);
    check("bank.r7", bank[7], 32'h12);

    for (int i = 0; i < 600; i++) cycle(rnd(), "rnd");

    // Reset in the middle of traffic, then all sources valid.
    begin
      vec_t v = rnd();
      v.rv = 3'b111;
      drive(v);
      #2;
      rst_async_n = 1'b0;
      @(negedge clk);
      check("mrst.busy", busy, '0);
      check("mrst.wen", rf_write_en, 1'b0);
      check("mrst.err", err_unreserved, 1'b0);
      check("mrst.widx", rf_write_index, '0);
      m_reset();
      drive(idle);
      @(posedge clk);
      #1;
      @(negedge clk);
      rst_async_n = 1'b1;
      @(posedge clk);
      #1;
      v = mk(0, 0, 3'b111, 2, 4, 6, 32'hA5, 0, 0, 0, 3'b001, 0, 3'b000, 0, 0);
      cycle(v, "post_rst");
    end

    for (int i = 0; i < 200; i++) cycle(rnd(), "rnd2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
